prime_checker: RTL and testbench
================================

PRIME_CHECKER -- requirements
Module: prime_checker

Interface
REQ-001 Parameter WIDTH, default 9, operand width in bits; legal range 4..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 number  input  WIDTH  operand, unsigned; captured on the accepting edge.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 done  output  1  one-cycle pulse; result valid.
REQ-008 result  output  1  1 = operand prime, 0 = not prime; held until the next done.

Function
REQ-009 The FSM SHALL have states IDLE, CHECK, TEST, DIV and DONE; busy, done and result SHALL be registered.
REQ-010 IDLE: start=1 SHALL capture number into N and move to CHECK on that edge (E0); start=0 SHALL hold IDLE.
REQ-011 start SHALL be ignored in every state other than IDLE, including DONE; the captured N SHALL NOT change mid-operation.
REQ-012 CHECK: N in {0,1} -> result 0; N in {2,3} -> result 1; N even and >=4 -> result 0; all of these SHALL go to DONE at E1.
REQ-013 CHECK, otherwise: set divisor D=3 and square S=9 (S is WIDTH+2 bits), then go to TEST.
REQ-014 TEST: S > N SHALL give result 1 and go to DONE; otherwise SHALL clear the remainder and bit counter and go to DIV.
REQ-015 DIV: a bit-serial restoring division of N by D SHALL take exactly WIDTH cycles; the remainder SHALL be WIDTH bits wide and no quotient SHALL be stored.
REQ-016 DIV, final cycle: remainder 0 -> result 0, go to DONE; otherwise D<=D+2, S<=S+4D+4 (old D), go to TEST.
REQ-017 DONE: done SHALL be high for exactly this one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 Latency, counted in edges after E0:
  - trivial cases: done at E1;
  - odd N below 9: done at E2;
  - otherwise: 1 + k*(WIDTH+1) + (1 if prime) edges, where k is the number of divisors tried.
REQ-019 Arithmetic SHALL NOT overflow for any WIDTH-bit N; S SHALL be compared at full width.

Reset
REQ-020 reset=1 SHALL asynchronously force:
  - state to IDLE;
  - busy, done and result to 0;
  - N, D, S, the remainder and the bit counter to 0.
REQ-021 Reset during CHECK, TEST, DIV or DONE SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-022 Macro PRIME_CHECKER_FACTOR_EN, when defined, SHALL add output port factor (WIDTH bits, registered, reset 0), updated in the same cycle as done.
REQ-023 factor value rules:
  - 2 for even N >= 4;
  - D for a composite N detected in DIV (its smallest prime factor);
  - 0 for a prime N and for N in {0,1}.
REQ-024 Without PRIME_CHECKER_FACTOR_EN, the factor port and its register SHALL be absent, and all other behaviour and timing SHALL be identical.

Verification
REQ-025 WIDTH=9, reset then N=0, 1, 2, 4 -> done at E1, result 0, 0, 1, 0; busy low the cycle after done.
REQ-026 WIDTH=9, N=5 -> done at E2, result 1; N=9 -> done at E11, result 0, factor 3 (with macro).
REQ-027 WIDTH=9:
  - N=25 -> done at E21, result 0, factor 5;
  - N=359 -> done at E82, result 1, factor 0;
  - N=361 -> result 0, factor 19.
REQ-028 WIDTH=9, N=9 with start held high through the operation and a second start pulse during DIV -> exactly one done; the next operation starts only from IDLE.
REQ-029 WIDTH=9, N=359 with reset asserted at E40 -> outputs 0 immediately, no done; then N=7 -> done at E2 after acceptance, result 1.
REQ-030 WIDTH=16, N=65521 -> result 1; N=65535 -> result 0, factor 3; exhaustive sweep 0..511 at WIDTH=9 matches a software primality model.

Source files
------------

// File: rtl/prime_checker.sv
// Sequential trial-division primality checker with a bit-serial restoring divider.
// Optional `PRIME_CHECKER_FACTOR_EN adds a registered smallest-factor output.
module prime_checker #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic             result
`ifdef PRIME_CHECKER_FACTOR_EN
  ,
  output logic [WIDTH-1:0] factor
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned SqW  = WIDTH + 2;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StTest,
    StDiv,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [SqW-1:0]   s_q, s_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             result_q, result_d;

  logic [CntW-1:0]  bit_idx;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_step;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    bit_idx   = CntW'(WIDTH - 1) - cnt_q;
    rem_shift = {rem_q, n_q[bit_idx]};
    rem_step  = (rem_shift >= {1'b0, d_q}) ? WIDTH'(rem_shift - {1'b0, d_q})
                                           : WIDTH'(rem_shift);
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    s_d      = s_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = number;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (n_q < WIDTH'(4)) begin
          // 0,1 -> not prime; 2,3 -> prime: exactly bit 1 of N.
          result_d = n_q[1];
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (!n_q[0]) begin
          result_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          d_d     = WIDTH'(3);
          s_d     = SqW'(9);
          state_d = StTest;
        end
      end
      StTest: begin
        if (s_q > {2'b00, n_q}) begin
          result_d = 1'b1;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d = rem_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          if (rem_step == '0) begin
            result_d = 1'b0;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            // (D+2)^2 = D^2 + 4D + 4
            d_d     = d_q + WIDTH'(2);
            s_d     = s_q + {d_q, 2'b00} + SqW'(4);
            state_d = StTest;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      n_q      <= '0;
      d_q      <= '0;
      s_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      s_q      <= s_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

`ifdef PRIME_CHECKER_FACTOR_EN
  logic [WIDTH-1:0] factor_q, factor_d;

  // Only a CHECK exit with N >= 4 is the even case; DIV exits are composites.
  always_comb begin
    factor_d = factor_q;
    if (done_d) begin
      case (state_q)
        StCheck: factor_d = (n_q < WIDTH'(4)) ? '0 : WIDTH'(2);
        StDiv:   factor_d = d_q;
        default: factor_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      factor_q <= '0;
    end else begin
      factor_q <= factor_d;
    end
  end

  assign factor = factor_q;
`endif

endmodule

// File: tb/tb_prime_checker.sv
// Directed self-checking bench for prime_checker at WIDTH=9 and WIDTH=16.
// Factor checks are compiled in only when PRIME_CHECKER_FACTOR_EN is defined.
module tb_prime_checker;

  localparam int Limit = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start9 = 1'b0;
  logic [8:0]  number9 = '0;
  logic        busy9, done9, result9;
  logic [8:0]  factor9;

  logic        start16 = 1'b0;
  logic [15:0] number16 = '0;
  logic        busy16, done16, result16;
  logic [15:0] factor16;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  prime_checker #(.WIDTH(9)) dut9 (
    .clk    (clk),
    .reset  (rst),
    .start  (start9),
    .number (number9),
    .busy   (busy9),
    .done   (done9),
`ifdef PRIME_CHECKER_FACTOR_EN
    .factor (factor9),
`endif
    .result (result9)
  );

  prime_checker #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .reset  (rst),
    .start  (start16),
    .number (number16),
    .busy   (busy16),
    .done   (done16),
`ifdef PRIME_CHECKER_FACTOR_EN
    .factor (factor16),
`endif
    .result (result16)
  );

`ifndef PRIME_CHECKER_FACTOR_EN
  assign factor9  = '0;
  assign factor16 = '0;
`endif

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int small_factor(int n);
    if (n < 2 || is_prime(n)) return 0;
    for (int d = 2; d <= n; d++) if (n % d == 0) return d;
    return 0;
  endfunction

  function automatic int lat_model(int n, int w);
    int k;
    if (n < 4 || n % 2 == 0) return 1;
    k = 0;
    for (int d = 3; d * d <= n; d += 2) begin
      k++;
      if (n % d == 0) return 1 + k * (w + 1);
    end
    return 1 + k * (w + 1) + 1;
  endfunction

  // Starts one WIDTH=9 operation and reports edges-after-E0 to done (Limit+ on timeout).
  task automatic run9(input int n, output int lat, output logic res, output int fac,
                      output logic busy_after);
    bit seen;
    @(negedge clk);
    start9  = 1'b1;
    number9 = 9'(n);
    @(posedge clk);
    #1 start9 = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= Limit) begin
      @(posedge clk);
      #1 lat++;
      if (done9) seen = 1'b1;
    end
    res = result9;
    fac = int'(factor9);
    @(posedge clk);
    #1 busy_after = busy9;
  endtask

  task automatic run16(input int n, output int lat, output logic res, output int fac);
    bit seen;
    @(negedge clk);
    start16  = 1'b1;
    number16 = 16'(n);
    @(posedge clk);
    #1 start16 = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= Limit) begin
      @(posedge clk);
      #1 lat++;
      if (done16) seen = 1'b1;
    end
    res = result16;
    fac = int'(factor16);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy9, done9, result9} !== 3'b000) begin
      fails++;
      $display("FAIL reset9: got %b want 000", {busy9, done9, result9});
    end
    checks++;
    if ({busy16, done16, result16} !== 3'b000) begin
      fails++;
      $display("FAIL reset16: got %b want 000", {busy16, done16, result16});
    end
`ifdef PRIME_CHECKER_FACTOR_EN
    checks++;
    if (factor9 !== 9'd0) begin
      fails++;
      $display("FAIL reset_factor: got %0d want 0", factor9);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag, input int n_tab[], input int lat_tab[],
                           input logic res_tab[], input int fac_tab[]);
    int lat, fac;
    logic res, ba;
    for (int i = 0; i < n_tab.size(); i++) begin
      run9(n_tab[i], lat, res, fac, ba);
      checks++;
      if (lat !== lat_tab[i]) begin
        fails++;
        $display("FAIL %s latency n=%0d: got %0d want %0d", tag, n_tab[i], lat, lat_tab[i]);
      end
      checks++;
      if (res !== res_tab[i]) begin
        fails++;
        $display("FAIL %s result n=%0d: got %b want %b", tag, n_tab[i], res, res_tab[i]);
      end
      checks++;
      if (ba !== 1'b0) begin
        fails++;
        $display("FAIL %s busy_after n=%0d: got %b want 0", tag, n_tab[i], ba);
      end
`ifdef PRIME_CHECKER_FACTOR_EN
      checks++;
      if (fac !== fac_tab[i]) begin
        fails++;
        $display("FAIL %s factor n=%0d: got %0d want %0d", tag, n_tab[i], fac, fac_tab[i]);
      end
`else
      if (fac_tab.size() != n_tab.size()) $display("note: factor table size differs");
`endif
    end
  endtask

  task automatic test_trivial();
    run_table("trivial", '{0, 1, 2, 4}, '{1, 1, 1, 1}, '{1'b0, 1'b0, 1'b1, 1'b0},
              '{0, 0, 0, 2});
  endtask

  task automatic test_division();
    run_table("division", '{5, 9, 25, 359, 361}, '{2, 11, 21, 82, 91},
              '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, '{0, 3, 5, 0, 19});
  endtask

  task automatic test_start_ignored();
    int dones, done_at;
    @(negedge clk);
    start9  = 1'b1;
    number9 = 9'd9;
    @(posedge clk);
    #1 number9 = 9'd4;
    dones   = 0;
    done_at = 0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) start9 = 1'b0;
      if (e == 6) start9 = 1'b1;
      if (done9) begin
        dones++;
        done_at = e;
      end
    end
    checks++;
    if (dones !== 1 || done_at !== 11) begin
      fails++;
      $display("FAIL hold_start: got %0d dones at E%0d want 1 at E11", dones, done_at);
    end
    checks++;
    if (result9 !== 1'b0) begin
      fails++;
      $display("FAIL hold_start result: got %b want 0", result9);
    end
`ifdef PRIME_CHECKER_FACTOR_EN
    checks++;
    if (factor9 !== 9'd3) begin
      fails++;
      $display("FAIL hold_start factor: got %0d want 3", factor9);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if ({busy9, done9} !== 2'b00) begin
      fails++;
      $display("FAIL hold_start idle: got busy,done=%b want 00", {busy9, done9});
    end
    @(posedge clk);
    #1 start9 = 1'b0;
    checks++;
    if (busy9 !== 1'b1) begin
      fails++;
      $display("FAIL hold_start reaccept: got busy=%b want 1", busy9);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done9, result9} !== 2'b10) begin
      fails++;
      $display("FAIL hold_start second op: got done,result=%b want 10", {done9, result9});
    end
    @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, fac, dones;
    logic res, ba;
    run9(5, lat, res, fac, ba);
    checks++;
    if (res !== 1'b1) begin
      fails++;
      $display("FAIL abort preload: got result %b want 1", res);
    end
    @(negedge clk);
    start9  = 1'b1;
    number9 = 9'd359;
    @(posedge clk);
    #1 start9 = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done9) dones++;
    end
    checks++;
    if (busy9 !== 1'b1) begin
      fails++;
      $display("FAIL abort busy at E40: got %b want 1", busy9);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy9, done9, result9} !== 3'b000) begin
      fails++;
      $display("FAIL abort async clear: got %b want 000", {busy9, done9, result9});
    end
    repeat (3) begin
      @(posedge clk);
      #1 if (done9) dones++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1 if (done9) dones++;
    end
    checks++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL abort no_done: got %0d done pulses want 0", dones);
    end
    run9(7, lat, res, fac, ba);
    checks++;
    if (lat !== 2 || res !== 1'b1) begin
      fails++;
      $display("FAIL abort restart n=7: got lat %0d res %b want lat 2 res 1", lat, res);
    end
  endtask

  task automatic test_width16();
    int lat, fac;
    logic res;
    run16(65521, lat, res, fac);
    checks++;
    if (lat !== 2161 || res !== 1'b1) begin
      fails++;
      $display("FAIL w16 n=65521: got lat %0d res %b want lat 2161 res 1", lat, res);
    end
    run16(65535, lat, res, fac);
    checks++;
    if (lat !== 18 || res !== 1'b0) begin
      fails++;
      $display("FAIL w16 n=65535: got lat %0d res %b want lat 18 res 0", lat, res);
    end
`ifdef PRIME_CHECKER_FACTOR_EN
    checks++;
    if (fac !== 3) begin
      fails++;
      $display("FAIL w16 factor n=65535: got %0d want 3", fac);
    end
`endif
  endtask

  task automatic test_sweep();
    int lat, fac;
    logic res, ba;
    for (int n = 0; n < 512; n++) begin
      run9(n, lat, res, fac, ba);
      checks++;
      if (res !== logic'(is_prime(n)) || lat !== lat_model(n, 9)) begin
        fails++;
        $display("FAIL sweep n=%0d: got res %b lat %0d want res %b lat %0d", n, res, lat,
                 is_prime(n), lat_model(n, 9));
      end
`ifdef PRIME_CHECKER_FACTOR_EN
      checks++;
      if (fac !== small_factor(n)) begin
        fails++;
        $display("FAIL sweep factor n=%0d: got %0d want %0d", n, fac, small_factor(n));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_trivial();
    test_division();
    test_start_ignored();
    test_reset_abort();
    test_width16();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
